// File: rtl/timer_counter_pkg.sv
// Shared definitions for timer_counter: register offsets, MODE codes, CTRL layout, FSM states.
// The optional prescaler is selected with the TIMER_PRESCALE_EN macro.
package timer_counter_pkg;

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Packed so that bit 0 = EN, [2:1] = MODE, bit 3 = IM.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_rd(input ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage

// File: rtl/timer_counter_prescaler.sv
// Tick divider for timer_counter: one tick every div+1 cycles, restarted by clr.
// Present only when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [PSC_W-1:0] div,
    output logic             tick
);

    logic [PSC_W-1:0] div_q, div_d;

    assign tick = (div_q == div);

    always_comb begin
        div_d = div_q + PSC_W'(1);
        if (clr || tick) div_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer (one-shot / periodic) with interrupt request.
// Optional PRESCALE register and tick divider enabled by defining TIMER_PRESCALE_EN.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    input  logic        We,
    output logic [31:0] DataOut,
    output logic        IntReq
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q, irq_d;
    logic             psc_clr;
    logic             tick;
    logic             wr_ctrl, wr_preset, en_wr;

    assign wr_ctrl   = We && (Addr[3:2] == OFF_CTRL);
    assign wr_preset = We && (Addr[3:2] == OFF_PRESET);
    // An EN=0 write landing in INT must stop a periodic reload immediately.
    assign en_wr     = wr_ctrl ? DataIn[0] : ctrl_q.en;

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   psc_q <= '0;
        else if (We && (Addr[3:2] == OFF_PRESCALE))  psc_q <= DataIn[PSC_W-1:0];
    end

    timer_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk   (clk),
        .reset (reset),
        .clr   (psc_clr),
        .div   (psc_q),
        .tick  (tick)
    );
`else
    logic [PSC_W-1:0] unused_psc;
    logic             unused_clr;
    assign unused_psc = '0;
    assign unused_clr = psc_clr;
    assign tick       = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{Addr, DataIn};

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
        psc_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                psc_clr = 1'b1;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q <= CNT_W'(1)) begin
                        count_d = '0;
                        irq_d   = 1'b1;
                        state_d = ST_INT;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            ST_INT: begin
                if (!en_wr) begin
                    state_d = ST_IDLE;
                end else if (ctrl_q.mode == MODE_PERIODIC) begin
                    irq_d   = 1'b0;
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // CPU writes take priority over hardware updates of CTRL and irq_flag.
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(DataIn[3:0]);
            irq_d  = 1'b0;
        end
        if (wr_preset) begin
            preset_d = DataIn[CNT_W-1:0];
            irq_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        DataOut = 32'd0;
        case (Addr[3:2])
            OFF_CTRL:     DataOut = ctrl_rd(ctrl_q);
            OFF_PRESET:   DataOut = 32'(preset_q);
            OFF_COUNT:    DataOut = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
            OFF_PRESCALE: DataOut = 32'(psc_q);
`else
            OFF_PRESCALE: DataOut = 32'd0;
`endif
            default:      DataOut = 32'd0;
        endcase
    end

    assign IntReq = ctrl_q.im & irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a timeline model predicts register reads and IntReq per cycle.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr, DataIn, DataOut;
    logic        We, IntReq;

    timer_counter dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .We      (We),
        .DataOut (DataOut),
        .IntReq  (IntReq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic        irq;
        longint      cyc;
        logic [1:0]  off;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    // Model: a run is enabled at edge s and disabled at edge d; everything else follows from timing rules.
    longint      s = 64'sd1 <<< 40;
    longint      d = -1;
    longint      P = 1;
    longint      preset = 0;
    logic [31:0] old_count = 0;
    logic [3:0]  ctrl_en = 0, ctrl_dis = 0;
    logic [31:0] psc_v = 0;

    function automatic bit periodic();
        return ctrl_en[2:1] == 2'b01;
    endfunction

    function automatic longint m_eff();
        return (preset == 0) ? 1 : preset;
    endfunction

    function automatic logic [31:0] cnt_at(input longint n);
        longint r, T;
        T = m_eff() * P + 2;
        if (n < s + 2) return old_count;
        r = n - (s + 2);
        if (periodic()) r = r % T;
        if (r < m_eff() * P) return 32'(preset - r / P);
        return 32'd0;
    endfunction

    function automatic logic exp_flag(input longint n);
        longint F, T;
        if (n >= d) return 1'b0;
        F = s + 2 + m_eff() * P;
        T = m_eff() * P + 2;
        if (n < F) return 1'b0;
        if (periodic()) return ((n - (s + 2)) % T) == m_eff() * P;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_ctrl(input longint n);
        if (n >= d) return ctrl_dis;
        if (!periodic() && n >= s + 3 + m_eff() * P) return ctrl_en & 4'hE;
        return ctrl_en;
    endfunction

    function automatic logic [31:0] exp_count(input longint n);
        if (n < d) return cnt_at(n);
        if (d == s + 1 && n > d) return cnt_at(d + 1);
        return cnt_at(d);
    endfunction

    function automatic logic [31:0] exp_dout(input longint n, input logic [1:0] off);
        case (off)
            2'd0:    return {28'd0, exp_ctrl(n)};
            2'd1:    return preset[31:0];
            2'd2:    return exp_count(n);
`ifdef TIMER_PRESCALE_EN
            default: return psc_v;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    task automatic apply(input logic [1:0] off, input logic [31:0] data);
        case (off)
            2'd0: begin
                if (data[0]) begin
                    ctrl_en = data[3:0];
                    s = cyc;
                    d = 64'sd1 <<< 41;
                end else begin
                    if (d > cyc) d = cyc;
                    ctrl_dis = data[3:0];
                end
            end
            2'd1: begin
                old_count = exp_count(cyc);
                s = 64'sd1 <<< 40;
                d = cyc - 999;
                preset = longint'(data);
            end
            2'd3: begin
`ifdef TIMER_PRESCALE_EN
                psc_v = {24'd0, data[7:0]};
                P = longint'(data[7:0]) + 1;
`endif
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic we, input logic [1:0] off, input logic [31:0] data);
        exp_t        e;
        logic [31:0] a;
        logic [3:0]  c;
        a = $urandom();
        a[3:2] = off;
        Addr = a;
        We = we;
        DataIn = data;
        c = exp_ctrl(cyc);
        e.dout = exp_dout(cyc, off);
        e.irq = c[3] & exp_flag(cyc);
        e.cyc = cyc;
        e.off = off;
        sb.push_back(e);
        @(posedge clk);
        cyc++;
        if (we) apply(off, data);
        #1;
    endtask

    task automatic idle();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) step(1'b1, 2'd2, $urandom());
`ifndef TIMER_PRESCALE_EN
        else if (r == 1) step(1'b1, 2'd3, $urandom());
`endif
        else step(1'b0, 2'($urandom_range(0, 3)), $urandom());
    endtask

    task automatic episode(input logic [31:0] prst, input logic [31:0] psc,
                           input logic [3:0] cv, input int dd);
        step(1'b1, 2'd1, prst);
`ifdef TIMER_PRESCALE_EN
        step(1'b1, 2'd3, psc);
`else
        if (psc[0]) idle();
`endif
        repeat ($urandom_range(0, 2)) idle();
        step(1'b1, 2'd0, ($urandom() & 32'hFFFF_FFF0) | {28'd0, cv} | 32'd1);
        for (int k = 1; k < dd; k++) idle();
        step(1'b1, 2'd0, $urandom() & 32'hFFFF_FFFE);
        repeat (4) idle();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (DataOut !== mon_e.dout || IntReq !== mon_e.irq) begin
                n_fail++;
                $display("FAIL sb cyc=%0d off=%0d: DataOut=%h IntReq=%b expected DataOut=%h IntReq=%b",
                         mon_e.cyc, mon_e.off, DataOut, IntReq, mon_e.dout, mon_e.irq);
            end
        end
    end

    initial begin
        reset = 1'b1;
        We = 1'b0;
        Addr = 32'd0;
        DataIn = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", {31'd0, IntReq}, 32'd0);
        chk("reset_dout", DataOut, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 32'd0);
        step(1'b1, 2'd2, 32'd7);
        step(1'b0, 2'd2, 32'd0);
        step(1'b0, 2'd3, 32'd0);

        episode(32'd5, 32'd0, 4'h9, 20);
        episode(32'd3, 32'd0, 4'hB, 17);
        episode(32'd4, 32'd0, 4'h1, 12);
        episode(32'd0, 32'd0, 4'h9, 6);
        episode(32'd1, 32'd0, 4'h9, 6);
        episode(32'd2, 32'd3, 4'h9, 15);
        episode(32'd2, 32'd0, 4'hB, 1);

        for (int i = 0; i < 30; i++)
            episode($urandom_range(0, 9), $urandom_range(0, 3),
                    4'($urandom_range(0, 15)), $urandom_range(1, 40));

        // Reset asserted mid-count must clear everything immediately.
        step(1'b1, 2'd1, 32'd100);
        step(1'b1, 2'd0, 32'h9);
        repeat (20) step(1'b0, 2'd2, 32'd0);
        reset = 1'b1;
        We = 1'b0;
        Addr = 32'h8;
        #1;
        chk("midreset_count", DataOut, 32'd0);
        chk("midreset_irq", {31'd0, IntReq}, 32'd0);
        Addr = 32'h0;
        #1;
        chk("midreset_ctrl", DataOut, 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        preset = 0;
        old_count = 0;
        ctrl_en = 0;
        ctrl_dis = 0;
        P = 1;
        psc_v = 0;
        s = 64'sd1 <<< 40;
        d = cyc - 999;
        for (int i = 0; i < 8; i++) step(1'b0, 2'(i % 4), 32'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
